uart_tx_buffered: RTL and testbench

- Response-side stage directly downstream of the command/ALU FSM.
- Accepts result/echo bytes over a valid/ready byte interface and buffers them in a small FIFO.
- Serialises each byte onto the UART TX pin as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- The FIFO absorbs 8-byte ALU result bursts and echo streams while the line runs at baud rate.

---
 rtl/uart_tx_buffered.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small circular FIFO in front of a
// start/data/stop serialiser. Bytes leave in exactly the order accepted.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CountFull = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Serialiser state
    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic            baud_end;
    logic [7:0]      head;

    // Handshake only looks at registered occupancy, so valid_i may depend on ready_o.
    assign ready_o       = (count_q != CountFull);
    assign push          = valid_i && ready_o;
    assign fifo_nonempty = (count_q != '0);
    assign baud_end      = (baud_q == BaudLast);
    assign head          = mem_q[rd_ptr_q];

    assign tx_o    = tx_q;
    assign count_o = count_q;
    assign busy_o  = (state_q != StIdle) || fifo_nonempty;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Serialiser next-state; pop is only raised when the FIFO holds a byte
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // FIFO storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed pushes feed an expected-byte queue,
// a mid-bit sampling UART receiver pops and compares each decoded frame.
module tb_uart_tx_buffered;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sb[$];
    int         falls[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data),
        .valid_i(valid),
        .ready_o(ready),
        .tx_o   (tx),
        .busy_o (busy),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte until accepted, then drop valid
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        data  = b;
        valid = 1'b1;
        while (!ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!ready) check("push_timeout", 32'(ready), 32'd1);
        sb.push_back(b);
        tick(1);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        tick(2);
        check("drain_scoreboard_empty", sb.size(), 0);
    endtask

    // Receiver monitor: k counts negedges since the first low sample of a start bit
    bit         rx_active = 1'b0;
    int         rx_k      = 0;
    logic [7:0] rx_byte;
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active = 1'b1;
                rx_k      = 0;
                falls.push_back(cyc);
            end
        end else begin
            rx_k++;
            if (rx_k == 2) begin
                check("rx_start_bit", 32'(tx), 32'd0);
            end else if (rx_k >= 6 && rx_k <= 34 && (rx_k % 4) == 2) begin
                rx_byte[(rx_k - 6) / 4] = tx;
            end else if (rx_k == 38) begin
                check("rx_stop_bit", 32'(tx), 32'd1);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected_byte: got %0h want none", rx_byte);
                end else begin
                    check("rx_byte", 32'(rx_byte), 32'(sb.pop_front()));
                end
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] vals [5];
        int         n;
        vals = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80};

        rst   = 1'b1;
        data  = 8'h00;
        valid = 1'b0;
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single byte 0xA5: E is the accepting edge
        data  = 8'hA5;
        valid = 1'b1;
        sb.push_back(8'hA5);
        tick(1);
        valid = 1'b0;
        check("single_E_count", 32'(count), 32'd1);
        check("single_E_tx", 32'(tx), 32'd1);
        check("single_E_busy", 32'(busy), 32'd1);
        tick(1);
        check("single_E1_tx_start", 32'(tx), 32'd0);
        check("single_E1_count", 32'(count), 32'd0);
        tick(4);
        check("single_E5_bit0", 32'(tx), 32'd1);
        tick(4);
        check("single_E9_bit1", 32'(tx), 32'd0);
        tick(31);
        check("single_E40_stop", 32'(tx), 32'd1);
        check("single_E40_busy", 32'(busy), 32'd1);
        tick(1);
        check("single_E41_busy", 32'(busy), 32'd0);
        check("single_E41_tx", 32'(tx), 32'd1);
        wait_idle(100);

        // Burst 0..7 with valid held high; bytes 5..7 stall on a full FIFO
        falls.delete();
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'(i);
            n    = 0;
            while (!ready && n < 200) begin
                check("burst_full_count", 32'(count), 32'd4);
                tick(1);
                n++;
            end
            if (n > 0) check("burst_reopen_count", 32'(count), 32'd3);
            sb.push_back(8'(i));
            tick(1);
            if (n > 0) check("burst_refill_count", 32'(count), 32'd4);
            if (i == 4) check("burst_full_ready", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        wait_idle(1000);
        check("burst_frames", falls.size(), 8);
        for (int i = 1; i < 8 && i < falls.size(); i++) begin
            check("burst_frame_spacing", falls[i] - falls[i-1], 40);
        end

        // Push lands on the same edge as the STOP-end pop (P = first pop edge)
        data  = 8'h11;
        valid = 1'b1;
        sb.push_back(8'h11);
        tick(1);
        data = 8'h22;
        sb.push_back(8'h22);
        tick(1);
        valid = 1'b0;
        check("pp_P_count", 32'(count), 32'd1);
        tick(39);
        data  = 8'h3C;
        valid = 1'b1;
        sb.push_back(8'h3C);
        check("pp_P39_count", 32'(count), 32'd1);
        tick(1);
        valid = 1'b0;
        check("pp_P40_count", 32'(count), 32'd1);
        check("pp_P40_tx_start", 32'(tx), 32'd0);
        wait_idle(300);

        // Reset during bit 3 of 0xFF with two bytes queued
        falls.delete();
        data  = 8'hFF;
        valid = 1'b1;
        tick(1);
        data = 8'h12;
        tick(1);
        data = 8'h34;
        tick(1);
        valid = 1'b0;
        check("mr_queued_count", 32'(count), 32'd2);
        tick(16);
        check("mr_bit3_tx", 32'(tx), 32'd1);
        rst = 1'b1;
        tick(1);
        check("mr_tx", 32'(tx), 32'd1);
        check("mr_count", 32'(count), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        falls.delete();
        tick(1);
        check("mr_ready_after", 32'(ready), 32'd1);
        tick(60);
        check("mr_no_frames", falls.size(), 0);
        check("mr_tx_idle", 32'(tx), 32'd1);
        push_byte(8'h81);
        wait_idle(100);

        // Loopback patterns
        for (int i = 0; i < 5; i++) begin
            push_byte(vals[i]);
        end
        wait_idle(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
